exmem_pipe: RTL and testbench
=============================

Name: exmem_pipe

Overview:
- Parametrised successor to the fixed two-deep EX/MEM latch; sits between the EX and MEM stages of the 8-bit MIPS pipeline.
- Carries branch PC, ALU result, store data, destination register and MEM/WB control through DEPTH elastic slots.
- Each slot has a valid bit; control is zeroed in empty slots, so an empty slot is a bubble.
- Adds stall with bubble collapse, flush, an occupancy count and an upstream ready signal.

Parameters:
- PC_W, 12, branch PC width
- DATA_W, 8, ALU result / store data width
- RADDR_W, 3, destination register index width
- DEPTH, 2, number of slots (>=1); latency in cycles when not stalled

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  MEM cannot accept the output slot this cycle
- flush  in  1  kill all in-flight entries (branch taken)
- in_valid  in  1  EX presents an entry
- in_ready  out  1  slot 0 accepts this cycle (combinational)
- in_new_branch_pc  in  PC_W  branch target
- in_alu_result  in  DATA_W  ALU output
- in_data_2  in  DATA_W  store data
- in_reg_write  in  RADDR_W  destination register
- in_MEM_mem_read_write  in  1  memory write enable
- in_MEM_pc_src  in  2  PC select
- in_WB_mem_or_alu  in  1  writeback mux select
- in_WB_reg_write_signal  in  1  register-file write enable
- out_valid  out  1  output slot holds a valid entry
- out_*  out  same widths as in_*  output slot fields
- occupancy  out  $clog2(DEPTH+1)  number of valid slots

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset: every slot gets valid=0 and all data and control fields=0 (pc_src=2'b00, mem_read_write=0, reg_write_signal=0). Outputs therefore read 0 and occupancy=0 in the cycle after reset. Reset overrides flush and stall.
- Ready chain (combinational):
  - ready[DEPTH-1] = !stall || !valid[DEPTH-1]
  - ready[k] = !valid[k] || ready[k+1]
  - in_ready = ready[0]
- Advance rule, when !rst && !flush, at each edge:
  - If ready[k]: slot k loads slot k-1 (slot 0 loads the inputs) and takes valid = upstream valid.
  - Else: slot k holds.
- Bubble rule: any slot loaded with valid=0 gets all control fields forced to 0. Data fields load unchanged.
- Bubble collapse: under stall, bubbles behind the stalled output slot are filled from upstream. Valid entries never overwrite each other and are never duplicated.
- Input acceptance: an input entry is accepted only when in_valid && in_ready. If in_ready=0, EX must hold its inputs.
- Flush (flush=1, rst=0):
  - Every slot gets valid=0 and control=0; data fields hold.
  - Flush beats stall. A same-cycle in_valid entry is discarded.
- Latency: with no stall, an entry accepted at edge N appears on out_* at edge N+DEPTH-1 (DEPTH cycles from input presentation).
- Outputs: out_* and out_valid come directly from slot DEPTH-1 registers (no combinational path from inputs).
- Occupancy: sum of the valid bits, registered. It is consistent with the slot state after every edge.
- DEPTH=1: a single slot; in_ready = !stall || !out_valid.

Optional Feature:
- Macro: EXMEM_PIPE_STATS_EN.
- With the macro defined, two extra output ports are present:
  - stat_stall_cnt[15:0]: increments on each cycle with stall && out_valid.
  - stat_bubble_cnt[15:0]: increments on each cycle with !out_valid.
- Both counters saturate at 16'hFFFF, clear on rst, and are not cleared by flush.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package exmem_pkg:
  - Control struct mem_ctrl_t with fields mem_read_write, pc_src[1:0], wb_mem_or_alu, wb_reg_write_signal.
  - Constants PC_SRC_SEQ=2'b00 and CTRL_BUBBLE (all zeros).
- Sub-module exmem_slot: one slot holding valid, data and control. Inputs are load, clear and upstream fields. It applies the bubble-zeroing rule. exmem_pipe generates DEPTH instances plus the ready chain and occupancy adder.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, out_MEM_pc_src=2'b00, occupancy=0; first entry after release appears DEPTH=2 cycles later.
- Streaming: in_valid=1 each cycle with in_alu_result=8'h01,8'h02,8'h03 → out_alu_result 01,02,03 on consecutive cycles starting 2 cycles after the first; occupancy=2 in steady state.
- Bubble collapse: output slot valid with 8'hAA, slot 0 empty, stall=1, in_valid=1 with 8'hBB → in_ready=1; next cycle occupancy=2 and out stays AA. Keep stall=1 → in_ready=0 and BB is held in slot 0.
- Flush with stall: flush=1, stall=1 and in_valid=1, with 2 valid entries carrying WB_reg_write_signal=1 → next cycle out_valid=0, out_WB_reg_write_signal=0, occupancy=0.
- DEPTH=1 build: in_valid=1 with in_reg_write=3'd5 → out_reg_write=5 one cycle later. Then stall=1 with a new input → in_ready=0 and out holds 5.
- Stats build (EXMEM_PIPE_STATS_EN): hold stall=1 with out_valid=1 for 70000 cycles → stat_stall_cnt=16'hFFFF. rst=1 → both counters 0.

Source files
------------

// File: rtl/exmem_pkg.sv
// Shared types and constants for the EX/MEM elastic pipeline.
package exmem_pkg;

    // MEM/WB control carried alongside each entry
    typedef struct packed {
        logic       mem_read_write;
        logic [1:0] pc_src;
        logic       wb_mem_or_alu;
        logic       wb_reg_write_signal;
    } mem_ctrl_t;

    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;

    // An empty slot carries this so it acts as a harmless bubble downstream
    localparam mem_ctrl_t  CTRL_BUBBLE = '{
        mem_read_write:      1'b0,
        pc_src:              PC_SRC_SEQ,
        wb_mem_or_alu:       1'b0,
        wb_reg_write_signal: 1'b0
    };

endpackage

// File: rtl/exmem_slot.sv
// One EX/MEM slot: valid bit, data fields and control.
// Control is forced to the bubble value whenever the slot becomes empty.
module exmem_slot
    import exmem_pkg::*;
#(
    parameter int PC_W    = 12,
    parameter int DATA_W  = 8,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic               i_up_valid,
    input  logic [PC_W-1:0]    i_up_pc,
    input  logic [DATA_W-1:0]  i_up_alu,
    input  logic [DATA_W-1:0]  i_up_data2,
    input  logic [RADDR_W-1:0] i_up_rd,
    input  mem_ctrl_t          i_up_ctrl,
    output logic               o_valid,
    output logic [PC_W-1:0]    o_pc,
    output logic [DATA_W-1:0]  o_alu,
    output logic [DATA_W-1:0]  o_data2,
    output logic [RADDR_W-1:0] o_rd,
    output mem_ctrl_t          o_ctrl
);

    logic               r_valid;
    logic [PC_W-1:0]    r_pc;
    logic [DATA_W-1:0]  r_alu;
    logic [DATA_W-1:0]  r_data2;
    logic [RADDR_W-1:0] r_rd;
    mem_ctrl_t          r_ctrl;

    // Reset wipes everything; clear (flush) kills valid/control but keeps data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_alu   <= '0;
            r_data2 <= '0;
            r_rd    <= '0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (i_load) begin
            r_valid <= i_up_valid;
            r_pc    <= i_up_pc;
            r_alu   <= i_up_alu;
            r_data2 <= i_up_data2;
            r_rd    <= i_up_rd;
            r_ctrl  <= i_up_valid ? i_up_ctrl : CTRL_BUBBLE;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_alu   = r_alu;
    assign o_data2 = r_data2;
    assign o_rd    = r_rd;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/exmem_pipe.sv
// EX/MEM elastic pipeline: DEPTH slots with stall, bubble collapse, flush,
// registered occupancy and combinational upstream ready.
// Optional macro EXMEM_PIPE_STATS_EN adds saturating stall/bubble counters.
module exmem_pipe
    import exmem_pkg::*;
#(
    parameter int PC_W    = 12,
    parameter int DATA_W  = 8,
    parameter int RADDR_W = 3,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_new_branch_pc,
    input  logic [DATA_W-1:0]          in_alu_result,
    input  logic [DATA_W-1:0]          in_data_2,
    input  logic [RADDR_W-1:0]         in_reg_write,
    input  logic                       in_MEM_mem_read_write,
    input  logic [1:0]                 in_MEM_pc_src,
    input  logic                       in_WB_mem_or_alu,
    input  logic                       in_WB_reg_write_signal,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_new_branch_pc,
    output logic [DATA_W-1:0]          out_alu_result,
    output logic [DATA_W-1:0]          out_data_2,
    output logic [RADDR_W-1:0]         out_reg_write,
    output logic                       out_MEM_mem_read_write,
    output logic [1:0]                 out_MEM_pc_src,
    output logic                       out_WB_mem_or_alu,
    output logic                       out_WB_reg_write_signal,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef EXMEM_PIPE_STATS_EN
    ,
    output logic [15:0]                stat_stall_cnt,
    output logic [15:0]                stat_bubble_cnt
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]              w_vld, w_up_vld, w_rdy, w_nvld;
    logic [DEPTH-1:0][PC_W-1:0]    w_pc, w_up_pc;
    logic [DEPTH-1:0][DATA_W-1:0]  w_alu, w_up_alu, w_d2, w_up_d2;
    logic [DEPTH-1:0][RADDR_W-1:0] w_rd, w_up_rd;
    mem_ctrl_t [DEPTH-1:0]         w_ctrl, w_up_ctrl;
    mem_ctrl_t                     w_in_ctrl;
    logic [OCC_W-1:0]              w_occ_nxt;
    logic [OCC_W-1:0]              r_occ;

    assign w_in_ctrl = '{
        mem_read_write:      in_MEM_mem_read_write,
        pc_src:              in_MEM_pc_src,
        wb_mem_or_alu:       in_WB_mem_or_alu,
        wb_reg_write_signal: in_WB_reg_write_signal
    };

    // Ready ripples back from the output slot: a slot can take new data if it
    // is empty or its successor is moving, which lets bubbles collapse
    always_comb begin
        w_rdy = '0;
        w_rdy[DEPTH-1] = !stall || !w_vld[DEPTH-1];
        for (int k = DEPTH-2; k >= 0; k--)
            w_rdy[k] = !w_vld[k] || w_rdy[k+1];
    end

    assign in_ready = w_rdy[0];

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        if (k == 0) begin : g_head
            assign w_up_vld[k]  = in_valid;
            assign w_up_pc[k]   = in_new_branch_pc;
            assign w_up_alu[k]  = in_alu_result;
            assign w_up_d2[k]   = in_data_2;
            assign w_up_rd[k]   = in_reg_write;
            assign w_up_ctrl[k] = w_in_ctrl;
        end else begin : g_link
            assign w_up_vld[k]  = w_vld[k-1];
            assign w_up_pc[k]   = w_pc[k-1];
            assign w_up_alu[k]  = w_alu[k-1];
            assign w_up_d2[k]   = w_d2[k-1];
            assign w_up_rd[k]   = w_rd[k-1];
            assign w_up_ctrl[k] = w_ctrl[k-1];
        end

        exmem_slot #(.PC_W(PC_W), .DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_rdy[k]),
            .i_clear    (flush),
            .i_up_valid (w_up_vld[k]),
            .i_up_pc    (w_up_pc[k]),
            .i_up_alu   (w_up_alu[k]),
            .i_up_data2 (w_up_d2[k]),
            .i_up_rd    (w_up_rd[k]),
            .i_up_ctrl  (w_up_ctrl[k]),
            .o_valid    (w_vld[k]),
            .o_pc       (w_pc[k]),
            .o_alu      (w_alu[k]),
            .o_data2    (w_d2[k]),
            .o_rd       (w_rd[k]),
            .o_ctrl     (w_ctrl[k])
        );
    end

    // Next-state valid bits summed so occupancy can be registered alongside the slots
    always_comb begin
        w_nvld    = '0;
        w_occ_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_nvld[k] = !flush && (w_rdy[k] ? w_up_vld[k] : w_vld[k]);
            w_occ_nxt = w_occ_nxt + OCC_W'(w_nvld[k]);
        end
    end

    // Occupancy register tracks the slot valid bits edge for edge
    always_ff @(posedge clk) begin
        if (rst) r_occ <= '0;
        else     r_occ <= w_occ_nxt;
    end

    assign occupancy               = r_occ;
    assign out_valid               = w_vld[DEPTH-1];
    assign out_new_branch_pc       = w_pc[DEPTH-1];
    assign out_alu_result          = w_alu[DEPTH-1];
    assign out_data_2              = w_d2[DEPTH-1];
    assign out_reg_write           = w_rd[DEPTH-1];
    assign out_MEM_mem_read_write  = w_ctrl[DEPTH-1].mem_read_write;
    assign out_MEM_pc_src          = w_ctrl[DEPTH-1].pc_src;
    assign out_WB_mem_or_alu       = w_ctrl[DEPTH-1].wb_mem_or_alu;
    assign out_WB_reg_write_signal = w_ctrl[DEPTH-1].wb_reg_write_signal;

`ifdef EXMEM_PIPE_STATS_EN
    logic [15:0] r_stall_cnt, r_bubble_cnt;

    // Saturating counters; only reset clears them, flush does not
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (stall && w_vld[DEPTH-1] && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (!w_vld[DEPTH-1] && r_bubble_cnt != 16'hFFFF)
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign stat_stall_cnt  = r_stall_cnt;
    assign stat_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_exmem_pipe.sv
// Scoreboard bench for exmem_pipe: directed scenarios plus randomized traffic,
// checked against an in-order queue of accepted entries.
// Stats checks are compiled in when EXMEM_PIPE_STATS_EN is defined.
module tb_exmem_pipe;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [11:0] pc;
        logic [7:0]  alu;
        logic [7:0]  d2;
        logic [2:0]  rd;
        logic        mrw;
        logic [1:0]  pcs;
        logic        wbm;
        logic        wbr;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
    ent_t cur = '0;
    logic in_ready, out_valid;
    logic [11:0] out_pc;
    logic [7:0]  out_alu, out_d2;
    logic [2:0]  out_rd;
    logic        out_mrw, out_wbm, out_wbr;
    logic [1:0]  out_pcs;
    logic [1:0]  occupancy;
    ent_t        w_out;
    assign w_out = {out_pc, out_alu, out_d2, out_rd, out_mrw, out_pcs, out_wbm, out_wbr};

    // DEPTH=1 instance
    logic d1_stall = 1'b0, d1_in_valid = 1'b0;
    logic [2:0] d1_rd = '0;
    logic d1_in_ready, d1_out_valid;
    logic [11:0] d1_out_pc;
    logic [7:0]  d1_out_alu, d1_out_d2;
    logic [2:0]  d1_out_rd;
    logic        d1_out_mrw, d1_out_wbm, d1_out_wbr;
    logic [1:0]  d1_out_pcs;
    logic        d1_occ;

`ifdef EXMEM_PIPE_STATS_EN
    logic [15:0] stat_stall_cnt, stat_bubble_cnt, d1_stat_stall, d1_stat_bubble;
`endif

    exmem_pipe #(.PC_W(12), .DATA_W(8), .RADDR_W(3), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_new_branch_pc(cur.pc), .in_alu_result(cur.alu), .in_data_2(cur.d2),
        .in_reg_write(cur.rd), .in_MEM_mem_read_write(cur.mrw), .in_MEM_pc_src(cur.pcs),
        .in_WB_mem_or_alu(cur.wbm), .in_WB_reg_write_signal(cur.wbr),
        .out_valid(out_valid), .out_new_branch_pc(out_pc), .out_alu_result(out_alu),
        .out_data_2(out_d2), .out_reg_write(out_rd), .out_MEM_mem_read_write(out_mrw),
        .out_MEM_pc_src(out_pcs), .out_WB_mem_or_alu(out_wbm),
        .out_WB_reg_write_signal(out_wbr), .occupancy(occupancy)
`ifdef EXMEM_PIPE_STATS_EN
        , .stat_stall_cnt(stat_stall_cnt), .stat_bubble_cnt(stat_bubble_cnt)
`endif
    );

    exmem_pipe #(.PC_W(12), .DATA_W(8), .RADDR_W(3), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .stall(d1_stall), .flush(1'b0),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .in_new_branch_pc(12'h0), .in_alu_result(8'h0), .in_data_2(8'h0),
        .in_reg_write(d1_rd), .in_MEM_mem_read_write(1'b0), .in_MEM_pc_src(2'b01),
        .in_WB_mem_or_alu(1'b0), .in_WB_reg_write_signal(1'b1),
        .out_valid(d1_out_valid), .out_new_branch_pc(d1_out_pc), .out_alu_result(d1_out_alu),
        .out_data_2(d1_out_d2), .out_reg_write(d1_out_rd), .out_MEM_mem_read_write(d1_out_mrw),
        .out_MEM_pc_src(d1_out_pcs), .out_WB_mem_or_alu(d1_out_wbm),
        .out_WB_reg_write_signal(d1_out_wbr), .occupancy(d1_occ)
`ifdef EXMEM_PIPE_STATS_EN
        , .stat_stall_cnt(d1_stat_stall), .stat_bubble_cnt(d1_stat_bubble)
`endif
    );

    // Reference model: entries in flight, oldest first
    ent_t q[$];
    int   npass = 0, ntot = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.pc  = 12'($urandom);
        e.alu = 8'($urandom);
        e.d2  = 8'($urandom);
        e.rd  = 3'($urandom);
        e.mrw = 1'($urandom);
        e.pcs = 2'($urandom);
        e.wbm = 1'($urandom);
        e.wbr = 1'($urandom);
        return e;
    endfunction

    function automatic ent_t mk(input logic [7:0] alu, input logic wbr);
        ent_t e = '0;
        e.alu = alu;
        e.pc  = {4'h3, alu};
        e.rd  = alu[2:0];
        e.pcs = 2'b10;
        e.wbr = wbr;
        return e;
    endfunction

    // Drive one cycle's inputs and record what the coming edge does to the model
    task automatic step(input logic r, input logic s, input logic f, input logic v,
                        input ent_t e, output logic acc);
        @(negedge clk);
        rst = r; stall = s; flush = f; in_valid = v; cur = e;
        #1;
        acc = 1'b0;
        if (mon_en && !r)
            chk("in_ready", 64'(in_ready), 64'(!s || (q.size() < DEPTH)));
        if (r || f) q.delete();
        else if (v && in_ready) begin
            q.push_back(e);
            acc = 1'b1;
        end
    endtask

    task automatic post();
        @(posedge clk);
        #3;
    endtask

    // Monitor: occupancy/bubble after each edge, entry compare when MEM consumes
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                chk("occupancy", 64'(occupancy), 64'(q.size()));
                if (!out_valid)
                    chk("bubble_ctrl", 64'({out_mrw, out_pcs, out_wbm, out_wbr}), 64'(0));
            end
            @(negedge clk);
            #2;
            if (mon_en && !rst && !flush && out_valid && !stall) begin
                if (q.size() == 0) begin
                    ntot++;
                    $display("FAIL out_unexpected: got entry %h expected none", w_out);
                end else begin
                    ent_t exp_e;
                    exp_e = q.pop_front();
                    chk("out_entry", 64'(w_out), 64'(exp_e));
                end
            end
        end
    end

    initial begin
        logic acc;
        ent_t pend;
        bit   have;

        // Reset with in_valid asserted
        step(1, 0, 0, 1, mk(8'h55, 1), acc);
        step(1, 0, 0, 1, mk(8'h55, 1), acc);
        post();
        mon_en = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_pc_src", 64'(out_pcs), 64'(0));
        chk("rst_occ", 64'(occupancy), 64'(0));

        // First-entry latency
        step(0, 0, 0, 1, mk(8'h11, 0), acc);
        post();
        chk("lat_early", 64'(out_valid), 64'(0));
        step(0, 0, 0, 0, '0, acc);
        post();
        chk("lat_valid", 64'(out_valid), 64'(1));
        chk("lat_alu", 64'(out_alu), 64'(8'h11));
        step(0, 0, 0, 0, '0, acc);
        post();

        // Streaming
        step(0, 0, 0, 1, mk(8'h01, 0), acc);
        post();
        step(0, 0, 0, 1, mk(8'h02, 0), acc);
        post();
        chk("str_01", 64'(out_alu), 64'(8'h01));
        chk("str_occ", 64'(occupancy), 64'(2));
        step(0, 0, 0, 1, mk(8'h03, 0), acc);
        post();
        chk("str_02", 64'(out_alu), 64'(8'h02));
        step(0, 0, 0, 0, '0, acc);
        post();
        chk("str_03", 64'(out_alu), 64'(8'h03));
        chk("str_03v", 64'(out_valid), 64'(1));
        step(0, 0, 0, 0, '0, acc);
        post();
        chk("str_drain", 64'(out_valid), 64'(0));

        // Bubble collapse under stall
        step(0, 0, 0, 1, mk(8'hAA, 1), acc);
        post();
        step(0, 0, 0, 0, '0, acc);
        post();
        chk("bc_out_aa", 64'(out_alu), 64'(8'hAA));
        step(0, 1, 0, 1, mk(8'hBB, 1), acc);
        chk("bc_ready1", 64'(in_ready), 64'(1));
        post();
        chk("bc_occ2", 64'(occupancy), 64'(2));
        chk("bc_hold_aa", 64'(out_alu), 64'(8'hAA));
        step(0, 1, 0, 1, mk(8'hCC, 1), acc);
        chk("bc_ready0", 64'(in_ready), 64'(0));
        post();
        chk("bc_still_aa", 64'(out_alu), 64'(8'hAA));

        // Flush beats stall and discards the same-cycle input
        step(0, 1, 1, 1, mk(8'hCC, 1), acc);
        post();
        chk("fl_valid", 64'(out_valid), 64'(0));
        chk("fl_wbr", 64'(out_wbr), 64'(0));
        chk("fl_occ", 64'(occupancy), 64'(0));

        // Randomized traffic; EX holds an unaccepted entry
        have = 1'b0;
        pend = '0;
        for (int i = 0; i < 800; i++) begin
            logic r, f, s;
            r = ($urandom_range(0, 99) == 0);
            f = ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 99) < 35);
            if (!have) begin
                have = ($urandom_range(0, 99) < 65);
                if (have) pend = rnd_ent();
            end
            step(r, s, f, have, pend, acc);
            if (r || f || acc) have = 1'b0;
        end
        step(0, 0, 0, 0, '0, acc);
        step(0, 0, 0, 0, '0, acc);
        step(0, 0, 0, 0, '0, acc);
        post();
        chk("rnd_drained", 64'(occupancy), 64'(0));

        // DEPTH=1 instance (main pipe idles with in_valid=0)
        @(negedge clk);
        d1_in_valid = 1'b1; d1_rd = 3'd5; d1_stall = 1'b0;
        post();
        chk("d1_valid", 64'(d1_out_valid), 64'(1));
        chk("d1_rd5", 64'(d1_out_rd), 64'(5));
        @(negedge clk);
        d1_stall = 1'b1; d1_rd = 3'd6;
        #1;
        chk("d1_ready0", 64'(d1_in_ready), 64'(0));
        post();
        chk("d1_hold5", 64'(d1_out_rd), 64'(5));
        chk("d1_occ", 64'(d1_occ), 64'(1));
        @(negedge clk);
        d1_in_valid = 1'b0; d1_stall = 1'b0;

`ifdef EXMEM_PIPE_STATS_EN
        step(1, 0, 0, 0, '0, acc);
        post();
        chk("st_rst_stall", 64'(stat_stall_cnt), 64'(0));
        step(0, 0, 0, 0, '0, acc);
        step(0, 0, 0, 0, '0, acc);
        step(0, 0, 0, 0, '0, acc);
        post();
        chk("st_bubble3", 64'(stat_bubble_cnt), 64'(3));
        step(0, 0, 0, 1, mk(8'h77, 1), acc);
        step(0, 1, 0, 0, '0, acc);
        post();
        chk("st_outv", 64'(out_valid), 64'(1));
        for (int i = 0; i < 70000; i++) step(0, 1, 0, 0, '0, acc);
        post();
        chk("st_stall_sat", 64'(stat_stall_cnt), 64'(16'hFFFF));
        step(0, 1, 1, 0, '0, acc);
        post();
        chk("st_flush_keep", 64'(stat_stall_cnt), 64'(16'hFFFF));
        step(1, 0, 0, 0, '0, acc);
        post();
        chk("st_clr_stall", 64'(stat_stall_cnt), 64'(0));
        chk("st_clr_bubble", 64'(stat_bubble_cnt), 64'(0));
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
